// File: rtl/cluster_pkg.sv
// cluster_pkg: shared widths, axis encodings and switch codes for the kd-tree cluster compare element.
package cluster_pkg;
    localparam int DIM_W    = 8;
    localparam int DIM      = 3;
    localparam int CENTER_W = DIM * DIM_W;
    localparam int AXIS_W   = 2;
    localparam logic [AXIS_W-1:0] AX_X = 2'd0;
    localparam logic [AXIS_W-1:0] AX_Y = 2'd1;
    localparam logic [AXIS_W-1:0] AX_Z = 2'd2;
    localparam logic [2:0] SW_NONE  = 3'b000;
    localparam logic [2:0] SW_LEFT  = 3'b110;
    localparam logic [2:0] SW_RIGHT = 3'b011;
endpackage

// File: rtl/cluster_ce_key_sel.sv
// cluster_ce_key_sel: picks the coordinate of a packed {X,Y,Z} center used as the sort key.
module cluster_ce_key_sel
    import cluster_pkg::*;
(
    input  logic [CENTER_W-1:0] i_center,
    input  logic [AXIS_W-1:0]   i_axis,
    output logic [DIM_W-1:0]    o_key
);
    // Axis 3 is unused and falls back to X.
    assign o_key = (i_axis == AX_Y) ? i_center[2*DIM_W-1:DIM_W] :
                   (i_axis == AX_Z) ? i_center[DIM_W-1:0] :
                                      i_center[3*DIM_W-1:2*DIM_W];
endmodule

// File: rtl/cluster_ce.sv
// cluster_ce: kd-tree node compare element; registered swap decision and reordered centers.
// Define CLUSTER_CE_ROTATE_EN to fully order the enabled triple in one evaluation.
module cluster_ce
    import cluster_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                sorting,
    input  logic                left_en,
    input  logic                right_en,
    input  logic [CENTER_W-1:0] left,
    input  logic [CENTER_W-1:0] parent,
    input  logic [CENTER_W-1:0] right,
    input  logic [CENTER_W-1:0] point_in,
    input  logic [AXIS_W-1:0]   axis,
    output logic                stable,
    output logic                left_switch,
    output logic                parent_switch,
    output logic                right_switch,
    output logic                go_left,
    output logic [CENTER_W-1:0] new_left,
    output logic [CENTER_W-1:0] new_parent,
    output logic [CENTER_W-1:0] new_right
);
    logic [DIM_W-1:0]    w_kl, w_kp, w_kr, w_kq;
    logic [CENTER_W-1:0] w_nl, w_np, w_nr;
    logic [2:0]          w_sw;
    logic                r_stable, r_go_left;
    logic [2:0]          r_sw;
    logic [CENTER_W-1:0] r_nl, r_np, r_nr;

    cluster_ce_key_sel u_kl (.i_center(left),     .i_axis(axis), .o_key(w_kl));
    cluster_ce_key_sel u_kp (.i_center(parent),   .i_axis(axis), .o_key(w_kp));
    cluster_ce_key_sel u_kr (.i_center(right),    .i_axis(axis), .o_key(w_kr));
    cluster_ce_key_sel u_kq (.i_center(point_in), .i_axis(axis), .o_key(w_kq));

`ifdef CLUSTER_CE_ROTATE_EN
    logic [CENTER_W-1:0] w_a, w_b, w_c;
    logic [DIM_W-1:0]    w_ka, w_kb, w_kc;
    // Three strict compare-exchanges; a disabled child's compares are skipped so its slot never moves.
    always_comb begin
        {w_a, w_b, w_c}    = {left, parent, right};
        {w_ka, w_kb, w_kc} = {w_kl, w_kp, w_kr};
        if (left_en && w_ka > w_kb) begin
            {w_a, w_b}   = {w_b, w_a};
            {w_ka, w_kb} = {w_kb, w_ka};
        end
        if (right_en && w_kb > w_kc) begin
            {w_b, w_c}   = {w_c, w_b};
            {w_kb, w_kc} = {w_kc, w_kb};
        end
        if (left_en && w_ka > w_kb) begin
            {w_a, w_b}   = {w_b, w_a};
            {w_ka, w_kb} = {w_kb, w_ka};
        end
        w_nl = sorting ? w_a : left;
        w_np = sorting ? w_b : parent;
        w_nr = sorting ? w_c : right;
        w_sw = sorting ? {w_a != left, w_b != parent, w_c != right} : SW_NONE;
    end
`else
    logic w_lp, w_pr;
    // Left/parent swap wins when both pairs are out of order.
    always_comb begin
        w_lp = sorting & left_en & (w_kl > w_kp);
        w_pr = sorting & right_en & (w_kp > w_kr);
        w_nl = w_lp ? parent : left;
        w_np = w_lp ? left : w_pr ? right : parent;
        w_nr = (!w_lp && w_pr) ? parent : right;
        w_sw = w_lp ? SW_LEFT : w_pr ? SW_RIGHT : SW_NONE;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable  <= 1'b0;
            r_go_left <= 1'b0;
            r_sw      <= SW_NONE;
            r_nl      <= '0;
            r_np      <= '0;
            r_nr      <= '0;
        end else if (en) begin
            r_stable  <= (w_sw == SW_NONE);
            r_go_left <= !sorting && (w_kq <= w_kp);
            r_sw      <= w_sw;
            r_nl      <= w_nl;
            r_np      <= w_np;
            r_nr      <= w_nr;
        end
    end

    assign stable = r_stable;
    assign go_left = r_go_left;
    assign {left_switch, parent_switch, right_switch} = r_sw;
    assign new_left = r_nl;
    assign new_parent = r_np;
    assign new_right = r_nr;
endmodule

// File: tb/tb_cluster_ce.sv
// tb_cluster_ce: directed checks of cluster_ce sort, point and enable-hold behaviour.
module tb_cluster_ce;
    import cluster_pkg::*;
    logic clk = 0, rst = 1, en = 1, sorting = 1, left_en = 1, right_en = 1;
    logic [CENTER_W-1:0] left = 0, parent = 0, right = 0, point_in = 0;
    logic [AXIS_W-1:0] axis = 0;
    logic stable, left_switch, parent_switch, right_switch, go_left;
    logic [CENTER_W-1:0] new_left, new_parent, new_right;
    int total = 0, passed = 0;

    cluster_ce dut (
        .clk(clk), .rst(rst), .en(en), .sorting(sorting), .left_en(left_en), .right_en(right_en),
        .left(left), .parent(parent), .right(right), .point_in(point_in), .axis(axis),
        .stable(stable), .left_switch(left_switch), .parent_switch(parent_switch),
        .right_switch(right_switch), .go_left(go_left),
        .new_left(new_left), .new_parent(new_parent), .new_right(new_right)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic [2:0] sw, input logic st, input logic gl,
                           input logic [23:0] l, input logic [23:0] p, input logic [23:0] r);
        chk({tag, ".sw"}, {29'd0, left_switch, parent_switch, right_switch}, {29'd0, sw});
        chk({tag, ".stable"}, {31'd0, stable}, {31'd0, st});
        chk({tag, ".go_left"}, {31'd0, go_left}, {31'd0, gl});
        chk({tag, ".nl"}, {8'd0, new_left}, {8'd0, l});
        chk({tag, ".np"}, {8'd0, new_parent}, {8'd0, p});
        chk({tag, ".nr"}, {8'd0, new_right}, {8'd0, r});
    endtask

    task automatic drive(input logic s, input logic le, input logic re, input logic [1:0] ax,
                         input logic [23:0] l, input logic [23:0] p, input logic [23:0] r,
                         input logic [23:0] pt);
        sorting = s; left_en = le; right_en = re; axis = ax;
        left = l; parent = p; right = r; point_in = pt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 1, 1, 0, 24'h500000, 24'h300000, 24'h700000, 24'h123456);
        tick(); tick();
        chk_all("reset", 3'b000, 0, 0, 0, 0, 0);
        rst = 0;
        tick();
        chk_all("post_reset_left_swap", 3'b110, 0, 0, 24'h300000, 24'h500000, 24'h700000);

        drive(1, 1, 1, 1, 24'h001000, 24'h009000, 24'h004000, 0);
        tick();
        chk_all("right_swap", 3'b011, 0, 0, 24'h001000, 24'h004000, 24'h009000);
        drive(1, 1, 0, 1, 24'h001000, 24'h009000, 24'h004000, 0);
        tick();
        chk_all("right_disabled", 3'b000, 1, 0, 24'h001000, 24'h009000, 24'h004000);
        drive(1, 0, 1, 0, 24'h900000, 24'h300000, 24'h500000, 0);
        tick();
        chk_all("left_disabled", 3'b000, 1, 0, 24'h900000, 24'h300000, 24'h500000);

        drive(1, 1, 1, 2, 24'h000010, 24'h000020, 24'h000020, 0);
        tick();
        chk_all("tie", 3'b000, 1, 0, 24'h000010, 24'h000020, 24'h000020);

        drive(1, 1, 1, 2, 24'h000080, 24'h000040, 24'h000010, 0);
        tick();
`ifdef CLUSTER_CE_ROTATE_EN
        chk_all("prio_rotate", 3'b101, 0, 0, 24'h000010, 24'h000040, 24'h000080);
`else
        chk_all("prio_ev1", 3'b110, 0, 0, 24'h000040, 24'h000080, 24'h000010);
        drive(1, 1, 1, 2, new_left, new_parent, new_right, 0);
        tick();
        chk_all("prio_ev2", 3'b011, 0, 0, 24'h000040, 24'h000010, 24'h000080);
        drive(1, 1, 1, 2, new_left, new_parent, new_right, 0);
        tick();
        chk_all("prio_ev3", 3'b110, 0, 0, 24'h000010, 24'h000040, 24'h000080);
`endif
        drive(1, 1, 1, 2, new_left, new_parent, new_right, 0);
        tick();
        chk_all("converged", 3'b000, 1, 0, 24'h000010, 24'h000040, 24'h000080);

        drive(0, 1, 1, 0, 24'h500000, 24'h400000, 24'h100000, 24'h400000);
        tick();
        chk_all("point_eq", 3'b000, 1, 1, 24'h500000, 24'h400000, 24'h100000);
        drive(0, 1, 1, 0, 24'h500000, 24'h400000, 24'h100000, 24'h410000);
        tick();
        chk_all("point_gt", 3'b000, 1, 0, 24'h500000, 24'h400000, 24'h100000);
        drive(0, 1, 1, 1, 24'h500000, 24'h400000, 24'h100000, 24'h41FF00);
        tick();
        chk_all("point_axis_y", 3'b000, 1, 0, 24'h500000, 24'h400000, 24'h100000);
        drive(0, 1, 1, 3, 24'h500000, 24'h400000, 24'h100000, 24'h3FFFFF);
        tick();
        chk_all("point_axis3_x", 3'b000, 1, 1, 24'h500000, 24'h400000, 24'h100000);

        en = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, 0, 24'h800000 + 24'(i), 24'h200000, 24'h100000, 0);
            tick();
            chk_all("hold", 3'b000, 1, 1, 24'h500000, 24'h400000, 24'h100000);
        end
        en = 1;
        drive(1, 1, 1, 0, 24'h800000, 24'h200000, 24'h900000, 0);
        tick();
        chk_all("reenable", 3'b110, 0, 0, 24'h200000, 24'h800000, 24'h900000);

        drive(0, 1, 1, 0, 24'h800000, 24'h200000, 24'h900000, 24'h100000);
        tick();
        chk({"pre_async", ".go_left"}, {31'd0, go_left}, 32'd1);
        #3 rst = 1;
        #1 chk_all("async_reset", 3'b000, 0, 0, 0, 0, 0);
        #1 rst = 0;
        tick();
        chk_all("after_async", 3'b000, 1, 1, 24'h800000, 24'h200000, 24'h900000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cluster_ce.md
Name: cluster_ce

Overview:
Compare element of one kd-tree node in the hardware k-means cluster tree. It holds the node's center and its two children's centers, compares them on the node's sorting axis, and outputs the swap decision plus the reordered centers. During point propagation it reports whether an incoming point descends left. The parent node FSM consumes {left_switch, parent_switch, right_switch} as its switch command.

Parameters:
DIM_W, 8, bits per coordinate
DIM, 3, coordinates per center (X, Y, Z)
CENTER_W, DIM*DIM_W (24), packed center width
AXIS_W, 2, axis select width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
en  in  1  evaluation enable; 0 holds all registered outputs
sorting  in  1  1 = sort mode; 0 = point-compare mode
left_en  in  1  left child present; 0 excludes left from comparison
right_en  in  1  right child present; 0 excludes right from comparison
left  in  CENTER_W  left child center
parent  in  CENTER_W  this node's center
right  in  CENTER_W  right child center
point_in  in  CENTER_W  point under propagation
axis  in  AXIS_W  compare axis
stable  out  1  triple already ordered, no swap
left_switch  out  1  left slot content changes
parent_switch  out  1  parent slot content changes
right_switch  out  1  right slot content changes
go_left  out  1  point goes to the left subtree
new_left  out  CENTER_W  reordered left center
new_parent  out  CENTER_W  reordered parent center
new_right  out  CENTER_W  reordered right center

Behaviour:
- Center packing is {X[23:16], Y[15:8], Z[7:0]}.
- Axis key: axis 0 selects X, 1 selects Y, 2 selects Z, 3 selects X. Comparisons are unsigned 8-bit.
- All outputs are registered, one-cycle latency from inputs sampled at posedge clk when en=1.
- Reset (asynchronous, rst=1): every output is 0, including stable and go_left.
- en=0: all outputs hold their values, also across mode changes.
- Sort mode (sorting=1), one pairwise swap per evaluation. Define lp = left_en & (key(left) > key(parent)) and pr = right_en & (key(parent) > key(right)).
  - lp=1 (has priority): new_left=parent, new_parent=left, new_right=right; switches = 110; stable=0.
  - lp=0, pr=1: new_left=left, new_parent=right, new_right=parent; switches = 011; stable=0.
  - Neither: outputs equal inputs; switches = 000; stable=1.
- Equal keys never swap; the comparison is strict.
- A disabled child's slot passes its input through unchanged.
- go_left is 0 in sort mode.
- Point mode (sorting=0):
  - go_left = key(point_in) <= key(parent).
  - Switches = 000; stable=1; new_* = inputs.
- Repeated evaluation converges within three cycles of unchanged inputs in the default build.
- rst mid-operation clears outputs immediately. The first evaluation after rst falls recomputes from the current inputs.

Optional Feature:
CLUSTER_CE_ROTATE_EN
- Defined: sort mode fully orders the enabled triple in one cycle (min to left, mid to parent, max to right). Each switch bit is 1 iff that slot's content changes:
  - L>P>R gives 101.
  - Either rotation gives 111.
  - stable=1 iff 000.
- Undefined: single pairwise swap as above; codes 101 and 111 never occur.

Decomposition:
- Package cluster_pkg holds DIM_W, DIM, CENTER_W, AXIS_W, the axis encoding constants (AX_X=0, AX_Y=1, AX_Z=2), and the switch code constants (SW_NONE=000, SW_LEFT=110, SW_RIGHT=011).
- One sub-module, cluster_ce_key_sel: combinational center+axis to 8-bit key. It is instantiated four times (left, parent, right, point).

Test Plan:
- Reset: assert rst with en=1 and arbitrary inputs -> all outputs 0 asynchronously. After release, next edge computes from inputs.
- Left swap: axis=0, L=0x500000, P=0x300000, R=0x700000, both enabled -> switches 110, new_left=0x300000, new_parent=0x500000, new_right=0x700000, stable=0.
- Right swap and disabled child: axis=1, L=0x001000, P=0x009000, R=0x004000 -> 011, new_parent=0x004000, new_right=0x009000. Same inputs with right_en=0 -> 000, stable=1.
- Tie and priority: axis=2, P=R=0x000020 -> stable. Then L=0x000080, P=0x000040, R=0x000010 -> 110 first; feeding outputs back converges to 0x10,0x40,0x80 on Z within 3 evaluations (1 cycle and code 101 with CLUSTER_CE_ROTATE_EN).
- Point mode: sorting=0, axis=0, P=0x400000, point_in=0x400000 -> go_left=1. point_in=0x410000 -> go_left=0. Switches 000 throughout.
- Enable hold: en=0 with changing inputs -> outputs unchanged for 5 cycles. Re-enable -> updated after 1 cycle.
